// File: rtl/pillar_pkg.sv
// rtl/pillar_pkg.sv - opcodes, instruction class codes and immediate sign-extension helper
package pillar_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_U = 7'b0110111;

  typedef enum logic [4:0] {
    IT_NONE = 5'd0,
    IT_R    = 5'd1,
    IT_I    = 5'd2,
    IT_S    = 5'd3,
    IT_B    = 5'd4,
    IT_L    = 5'd5,
    IT_U    = 5'd6
  } itype_t;

  // Immediates are built at this width and sliced down to XLEN by the user (XLEN <= 64).
  localparam int IMM_W = 64;

  // Sign-extend the low nbits of raw to IMM_W bits.
  function automatic logic [IMM_W-1:0] sext_imm(input logic [31:0] raw, input int unsigned nbits);
    logic signed [IMM_W-1:0] wide;
    wide = $signed({32'b0, raw}) <<< (IMM_W - nbits);
    return wide >>> (IMM_W - nbits);
  endfunction

endpackage

// File: rtl/rv_regfile.sv
// rtl/rv_regfile.sv - NREG x XLEN register file, two async read ports, one sync write port, x0 reads 0
module rv_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_idx,
  input  logic [AW-1:0]   rs2_idx,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_idx,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] mem [NREG];

  // Synchronous write; reset clears every entry and blocks a write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_en && wr_idx != '0) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Asynchronous read of the pre-edge contents; x0 is hardwired to zero.
  always_comb begin
    rs1_data = (rs1_idx == '0) ? '0 : mem[rs1_idx];
    rs2_data = (rs2_idx == '0) ? '0 : mem[rs2_idx];
  end

endmodule

// File: rtl/rv_decode_sb.sv
// rtl/rv_decode_sb.sv - decode stage with register file and write-back scoreboard; RV_DECODE_BYPASS_EN enables wb forwarding
module rv_decode_sb
  import pillar_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_ra,
  output logic [XLEN-1:0] out_rb,
  output logic [XLEN-1:0] out_pass,
  output logic [4:0]      out_itype,
  output logic [AW-1:0]   out_rd,
  output logic            out_we,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] rf1, rf2, v1, v2;
  logic [NREG-1:0] busy, busy_nxt;
  itype_t          itype;
  logic            use1, use2, has_rd, wr;
  logic            byp1, byp2, hazard, accept;
  logic [IMM_W-1:0] imm_i64, imm_s64, imm_b64, imm_u64;
  logic [XLEN-1:0] nxt_ra, nxt_rb, nxt_pass;
  logic            unused_bits;

  assign rs1 = AW'(in_ir[19:15]);
  assign rs2 = AW'(in_ir[24:20]);
  assign rd  = AW'(in_ir[11:7]);

  rv_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .rs1_idx  (rs1),
    .rs2_idx  (rs2),
    .rs1_data (rf1),
    .rs2_data (rf2),
    .wr_en    (wb_valid),
    .wr_idx   (wb_rd),
    .wr_data  (wb_data)
  );

  // Classify the opcode and note which source fields the class actually reads.
  always_comb begin
    itype = IT_NONE;
    use1  = 1'b0;
    use2  = 1'b0;
    case (in_ir[6:0])
      OP_R:    begin itype = IT_R; use1 = 1'b1; use2 = 1'b1; end
      OP_I:    begin itype = IT_I; use1 = 1'b1; end
      OP_S:    begin itype = IT_S; use1 = 1'b1; use2 = 1'b1; end
      OP_B:    begin itype = IT_B; use1 = 1'b1; use2 = 1'b1; end
      OP_L:    begin itype = IT_L; use1 = 1'b1; end
      OP_U:    begin itype = IT_U; end
      default: begin itype = IT_NONE; end
    endcase
  end

  assign has_rd = (itype == IT_R) || (itype == IT_I) || (itype == IT_L) || (itype == IT_U);
  assign wr     = has_rd && (rd != '0);

  assign imm_i64 = sext_imm({20'b0, in_ir[31:20]}, 12);
  assign imm_s64 = sext_imm({20'b0, in_ir[31:25], in_ir[11:7]}, 12);
  assign imm_b64 = sext_imm({19'b0, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0}, 13);
  assign imm_u64 = sext_imm({in_ir[31:12], 12'b0}, 32);

`ifdef RV_DECODE_BYPASS_EN
  // A busy source whose writer is on the wb port this cycle takes wb_data directly.
  assign byp1 = busy[rs1] && wb_valid && (wb_rd == rs1);
  assign byp2 = busy[rs2] && wb_valid && (wb_rd == rs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign v1 = byp1 ? wb_data : rf1;
  assign v2 = byp2 ? wb_data : rf2;

  // busy[0] is never set, so x0 sources can never stall.
  assign hazard   = (use1 && busy[rs1] && !byp1) || (use2 && busy[rs2] && !byp2);
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Map operands and immediates onto the three output slots by class.
  always_comb begin
    nxt_ra   = '0;
    nxt_rb   = '0;
    nxt_pass = '0;
    case (itype)
      IT_R: begin nxt_ra = v1;                   nxt_rb = v2; end
      IT_I: begin nxt_ra = v1;                   nxt_rb = imm_i64[XLEN-1:0]; end
      IT_S: begin nxt_ra = imm_s64[XLEN-1:0];    nxt_rb = v1; nxt_pass = v2; end
      IT_B: begin nxt_ra = v1;                   nxt_rb = v2; nxt_pass = imm_b64[XLEN-1:0]; end
      IT_L: begin nxt_ra = imm_i64[XLEN-1:0];    nxt_rb = v1; end
      IT_U: begin nxt_pass = imm_u64[XLEN-1:0]; end
      default: ;
    endcase
  end

  // Output bundle register: load on accept, drop when consumed, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ra    <= '0;
      out_rb    <= '0;
      out_pass  <= '0;
      out_itype <= IT_NONE;
      out_rd    <= '0;
      out_we    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_ra    <= nxt_ra;
      out_rb    <= nxt_rb;
      out_pass  <= nxt_pass;
      out_itype <= itype;
      out_rd    <= has_rd ? rd : '0;
      out_we    <= wr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Scoreboard next state: write-back clears first so a same-edge new writer wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid && wb_rd != '0) busy_nxt[wb_rd] = 1'b0;
    if (accept && wr)            busy_nxt[rd]    = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  assign unused_bits = ^{in_ir[14:12], imm_i64, imm_s64, imm_b64, imm_u64};

endmodule

// File: tb/tb_rv_decode_sb.sv
// tb/tb_rv_decode_sb.sv - directed and randomized checks of rv_decode_sb against a behavioural model
module tb_rv_decode_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
`ifdef RV_DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0, in_ready;
  logic [31:0]     in_ir = '0;
  logic            out_valid, out_ready = 1'b0;
  logic [XLEN-1:0] out_ra, out_rb, out_pass;
  logic [4:0]      out_itype;
  logic [AW-1:0]   out_rd;
  logic            out_we;
  logic            wb_valid = 1'b0;
  logic [AW-1:0]   wb_rd = '0;
  logic [XLEN-1:0] wb_data = '0;

  rv_decode_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ra(out_ra), .out_rb(out_rb), .out_pass(out_pass),
    .out_itype(out_itype), .out_rd(out_rd), .out_we(out_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_rf [NREG];
  bit          m_busy [NREG];
  bit          m_valid;
  logic [31:0] m_ra, m_rb, m_pass;
  int          m_itype, m_rd;
  bit          m_we;
  int          wbq[$];

  function automatic int cls_of(input logic [31:0] ir);
    case (ir[6:0])
      7'b0110011: return 1;
      7'b0010011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      7'b0000011: return 5;
      7'b0110111: return 6;
      default:    return 0;
    endcase
  endfunction

  function automatic bit forwarded(input int s);
    return BYP && s != 0 && m_busy[s] && wb_valid && int'(wb_rd) == s;
  endfunction

  function automatic logic [31:0] src_val(input int s);
    return forwarded(s) ? wb_data : m_rf[s];
  endfunction

  function automatic bit stalls(input int s);
    return s != 0 && m_busy[s] && !forwarded(s);
  endfunction

  always @(negedge clk) begin : model
    int cls, s1, s2, d, ii, is, ib;
    bit u1, u2, er, acc;
    logic [31:0] a, b;
    if (reset) begin
      m_valid = 0;
      for (int i = 0; i < NREG; i++) begin m_rf[i] = '0; m_busy[i] = 0; end
    end else begin
      cls = cls_of(in_ir);
      s1 = int'(in_ir[19:15]); s2 = int'(in_ir[24:20]); d = int'(in_ir[11:7]);
      u1 = cls inside {1, 2, 3, 4, 5};
      u2 = cls inside {1, 3, 4};
      er = (!m_valid || out_ready) && !(u1 && stalls(s1)) && !(u2 && stalls(s2));
      check_eq("in_ready", in_ready, er);
      check_eq("out_valid", out_valid, m_valid);
      if (m_valid) begin
        check_eq("out_ra", out_ra, m_ra);
        check_eq("out_rb", out_rb, m_rb);
        check_eq("out_pass", out_pass, m_pass);
        check_eq("out_itype", out_itype, m_itype);
        check_eq("out_rd", out_rd, m_rd);
        check_eq("out_we", out_we, m_we);
        if (out_ready && m_we) wbq.push_back(m_rd);
      end
      acc = in_valid && er;
      if (acc) begin
        a = src_val(s1); b = src_val(s2);
        ii = int'(in_ir[31:20]);                   if (ii >= 2048) ii -= 4096;
        is = int'({in_ir[31:25], in_ir[11:7]});    if (is >= 2048) is -= 4096;
        ib = int'({in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8]}) * 2;
        if (ib >= 4096) ib -= 8192;
        m_ra = 0; m_rb = 0; m_pass = 0;
        case (cls)
          1: begin m_ra = a;  m_rb = b; end
          2: begin m_ra = a;  m_rb = ii; end
          3: begin m_ra = is; m_rb = a; m_pass = b; end
          4: begin m_ra = a;  m_rb = b; m_pass = ib; end
          5: begin m_ra = ii; m_rb = a; end
          6: m_pass = in_ir & 32'hFFFF_F000;
          default: ;
        endcase
        m_itype = cls;
        m_rd    = (cls inside {1, 2, 5, 6}) ? d : 0;
        m_we    = (cls inside {1, 2, 5, 6}) && d != 0;
        m_valid = 1;
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (wb_valid && wb_rd != 0) begin
        m_rf[wb_rd]   = wb_data;
        m_busy[wb_rd] = 0;
      end
      if (acc && m_we) m_busy[d] = 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit rst, input bit v, input logic [31:0] ir, input bit ordy,
                      input bit wv, input int wrd, input logic [31:0] wd);
    @(posedge clk); #1;
    reset = rst; in_valid = v; in_ir = ir; out_ready = ordy;
    wb_valid = wv; wb_rd = AW'(wrd); wb_data = wd;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [7];
    logic [31:0] ir;
    ops = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b1100011, 7'b0000011, 7'b0110111, 7'b0};
    ops[6] = 7'($urandom);
    ir = $urandom;
    ir[6:0]   = ops[$urandom_range(0, 6)];
    ir[11:7]  = 5'($urandom_range(0, 7));
    ir[19:15] = 5'($urandom_range(0, 7));
    ir[24:20] = 5'($urandom_range(0, 7));
    return ir;
  endfunction

  localparam logic [31:0] ADDI_X1 = 32'h0050_0093;
  localparam logic [31:0] ADD_X2  = 32'h0010_8133;
  localparam logic [31:0] SW_X2   = 32'hFE20_AE23;
  localparam logic [31:0] ADDI_X4 = 32'h0010_0213;
  localparam logic [31:0] ADDI_X5 = 32'h0020_0293;
  localparam logic [31:0] ADDI_X3 = 32'h0030_0193;
  localparam logic [31:0] SW_X7   = 32'h0070_A023;
  localparam logic [31:0] SW_X0   = 32'h0000_2023;

  initial begin
    repeat (2) @(posedge clk);
    step(0, 0, 0, 1, 0, 0, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_ra", out_ra, 0);
    check_eq("rst_pass", out_pass, 0);
    check_eq("rst_itype", out_itype, 0);
    check_eq("rst_busy", dut.busy, 0);

    // ADDI x1,x0,5
    step(0, 1, ADDI_X1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check_eq("t1_valid", out_valid, 1);
    check_eq("t1_itype", out_itype, 2);
    check_eq("t1_rb", out_rb, 5);
    check_eq("t1_rd", out_rd, 1);
    check_eq("t1_we", out_we, 1);
    check_eq("t1_busy1", dut.busy[1], 1);

    // ADD x2,x1,x1 against busy x1
    step(0, 1, ADD_X2, 1, 0, 0, 0);
    check_eq("t2_stall", in_ready, 0);
    step(0, 1, ADD_X2, 1, 1, 1, 5);
    check_eq("t2_wb_ready", in_ready, BYP);
    if (!BYP) begin
      step(0, 1, ADD_X2, 1, 0, 0, 0);
      check_eq("t2_ready", in_ready, 1);
    end
    step(0, 0, 0, 1, 0, 0, 0);
    check_eq("t2_valid", out_valid, 1);
    check_eq("t2_ra", out_ra, 5);
    check_eq("t2_rb", out_rb, 5);

    // SW x2,-4(x1) with x1=0x100, x2=7
    step(0, 0, 0, 1, 1, 1, 32'h100);
    step(0, 0, 0, 1, 1, 2, 7);
    step(0, 1, SW_X2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check_eq("t3_itype", out_itype, 3);
    check_eq("t3_ra", out_ra, 32'hFFFF_FFFC);
    check_eq("t3_rb", out_rb, 32'h100);
    check_eq("t3_pass", out_pass, 7);
    check_eq("t3_we", out_we, 0);

    // back-pressure hold, then one bundle per cycle
    for (int i = 0; i < 3; i++) begin
      step(0, 1, ADDI_X4, 0, 0, 0, 0);
      check_eq("t4_ready", in_ready, 0);
      check_eq("t4_hold_ra", out_ra, 32'hFFFF_FFFC);
      check_eq("t4_busy4", dut.busy[4], 0);
    end
    step(0, 1, ADDI_X4, 1, 0, 0, 0);
    check_eq("t4_rel_ready", in_ready, 1);
    step(0, 1, ADDI_X5, 1, 0, 0, 0);
    check_eq("t4_rd4", out_rd, 4);
    step(0, 0, 0, 0, 0, 0, 0);
    check_eq("t4_rd5", out_rd, 5);
    check_eq("t4_busy5", dut.busy[5], 1);

    // reset with a held bundle and a busy register; wb in the reset cycle is ignored
    step(1, 0, 0, 0, 1, 7, 32'h77);
    step(0, 1, SW_X7, 1, 0, 0, 0);
    check_eq("t6_valid", out_valid, 0);
    check_eq("t6_busy", dut.busy, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check_eq("t6_rb_x1", out_rb, 0);
    check_eq("t6_pass_x7", out_pass, 0);

    // same-edge set and clear of x3; wb to x0 is a no-op
    step(0, 1, ADDI_X3, 1, 1, 3, 32'h33);
    step(0, 0, 0, 1, 0, 0, 0);
    check_eq("t5_busy3", dut.busy[3], 1);
    step(0, 0, 0, 1, 1, 0, 32'hFFFF);
    step(0, 1, SW_X0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check_eq("t5_x0_rb", out_rb, 0);
    check_eq("t5_x0_pass", out_pass, 0);

    // randomized traffic with an execute stage writing back consumed bundles
    step(1, 0, 0, 1, 0, 0, 0);
    wbq.delete();
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(0, 599) == 0);
      in_valid  = ($urandom_range(0, 9) < 8);
      in_ir     = rand_instr();
      out_ready = ($urandom_range(0, 9) < 7);
      if (reset) wbq.delete();
      if (wbq.size() > 0 && $urandom_range(0, 2) == 0) begin
        wb_valid = 1; wb_rd = AW'(wbq.pop_front()); wb_data = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        wb_valid = 1; wb_rd = AW'($urandom_range(0, 7)); wb_data = $urandom;
      end else begin
        wb_valid = 0;
      end
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
